// File: rtl/y86_execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, branch/cmov condition and the E->M pipeline register.
// Optional macro CC_SUPPRESS_EN blocks CC updates while an exception is pending or the instruction is not AOK.
module y86_execute_stage #(
  parameter int WIDTH      = 64,
  parameter int STACK_STEP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             bubble_i,
  input  logic             exc_i,
  input  logic [2:0]       e_stat_i,
  input  logic [3:0]       e_icode_i,
  input  logic [3:0]       e_ifun_i,
  input  logic [WIDTH-1:0] e_valA_i,
  input  logic [WIDTH-1:0] e_valB_i,
  input  logic [WIDTH-1:0] e_valC_i,
  input  logic [3:0]       e_dstE_i,
  input  logic [3:0]       e_dstM_i,
  output logic [2:0]       m_stat_o,
  output logic [3:0]       m_icode_o,
  output logic             m_cnd_o,
  output logic [WIDTH-1:0] m_valE_o,
  output logic [WIDTH-1:0] m_valA_o,
  output logic [3:0]       m_dstE_o,
  output logic [3:0]       m_dstM_o,
  output logic [2:0]       cc_o
);

  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [2:0] CC_RESET = 3'b100;

  localparam logic [WIDTH-1:0] STEP_POS = WIDTH'(STACK_STEP);
  localparam logic [WIDTH-1:0] STEP_NEG = ~STEP_POS + 1'b1;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alufun;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] val_e;
  logic             alu_valid;
  logic             zf;
  logic             sf;
  logic             of;
  logic             cc_allow;
  logic             cond_true;
  logic             e_cnd;
  logic [3:0]       e_dst_e;

  logic [2:0]       cc_d,      cc_q;
  logic [2:0]       m_stat_d,  m_stat_q;
  logic [3:0]       m_icode_d, m_icode_q;
  logic             m_cnd_d,   m_cnd_q;
  logic [WIDTH-1:0] m_val_e_d, m_val_e_q;
  logic [WIDTH-1:0] m_val_a_d, m_val_a_q;
  logic [3:0]       m_dst_e_d, m_dst_e_q;
  logic [3:0]       m_dst_m_d, m_dst_m_q;

  always_comb begin
    alu_a = '0;
    unique case (e_icode_i)
      I_OPQ, I_CMOV:                alu_a = e_valA_i;
      I_IRMOV, I_RMMOV, I_MRMOV:    alu_a = e_valC_i;
      I_CALL, I_PUSH:               alu_a = STEP_NEG;
      I_RET, I_POP:                 alu_a = STEP_POS;
      default:                      alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    unique case (e_icode_i)
      I_RMMOV, I_MRMOV, I_OPQ,
      I_CALL, I_PUSH, I_RET, I_POP: alu_b = e_valB_i;
      default:                      alu_b = '0;
    endcase
  end

  assign alufun = (e_icode_i == I_OPQ) ? e_ifun_i : ALU_ADD;
  assign sum    = alu_b + alu_a;
  assign diff   = alu_b - alu_a;

  // Overflow is a sign check on the operands against the result sign.
  always_comb begin
    val_e     = '0;
    of        = 1'b0;
    alu_valid = 1'b1;
    unique case (alufun)
      ALU_ADD: begin
        val_e = sum;
        of    = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != alu_b[WIDTH-1]);
      end
      ALU_SUB: begin
        val_e = diff;
        of    = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (diff[WIDTH-1] != alu_b[WIDTH-1]);
      end
      ALU_AND: val_e = alu_b & alu_a;
      ALU_XOR: val_e = alu_b ^ alu_a;
      default: alu_valid = 1'b0;
    endcase
  end

  assign zf = (val_e == '0);
  assign sf = val_e[WIDTH-1];

`ifdef CC_SUPPRESS_EN
  assign cc_allow = !exc_i && (e_stat_i == STAT_AOK);
`else
  logic unused_exc;
  assign unused_exc = exc_i;
  assign cc_allow   = 1'b1;
`endif

  always_comb begin
    cc_d = cc_q;
    if ((e_icode_i == I_OPQ) && alu_valid && !stall_i && cc_allow) begin
      cc_d = {zf, sf, of};
    end
  end

  // Condition uses the flags already registered, not the ones this OPQ produces.
  always_comb begin
    cond_true = 1'b0;
    unique case (e_ifun_i)
      4'h0:    cond_true = 1'b1;
      4'h1:    cond_true = (cc_q[1] ^ cc_q[0]) | cc_q[2];
      4'h2:    cond_true = cc_q[1] ^ cc_q[0];
      4'h3:    cond_true = cc_q[2];
      4'h4:    cond_true = ~cc_q[2];
      4'h5:    cond_true = ~(cc_q[1] ^ cc_q[0]);
      4'h6:    cond_true = ~(cc_q[1] ^ cc_q[0]) & ~cc_q[2];
      default: cond_true = 1'b0;
    endcase
  end

  assign e_cnd   = ((e_icode_i == I_CMOV) || (e_icode_i == I_JXX)) ? cond_true : 1'b0;
  assign e_dst_e = ((e_icode_i == I_CMOV) && !e_cnd) ? RNONE : e_dstE_i;

  // Stall outranks bubble so a held instruction is never overwritten.
  always_comb begin
    m_stat_d  = m_stat_q;
    m_icode_d = m_icode_q;
    m_cnd_d   = m_cnd_q;
    m_val_e_d = m_val_e_q;
    m_val_a_d = m_val_a_q;
    m_dst_e_d = m_dst_e_q;
    m_dst_m_d = m_dst_m_q;
    if (!stall_i) begin
      if (bubble_i) begin
        m_stat_d  = STAT_AOK;
        m_icode_d = I_NOP;
        m_cnd_d   = 1'b0;
        m_val_e_d = '0;
        m_val_a_d = '0;
        m_dst_e_d = RNONE;
        m_dst_m_d = RNONE;
      end else begin
        m_stat_d  = e_stat_i;
        m_icode_d = e_icode_i;
        m_cnd_d   = e_cnd;
        m_val_e_d = val_e;
        m_val_a_d = e_valA_i;
        m_dst_e_d = e_dst_e;
        m_dst_m_d = e_dstM_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q      <= CC_RESET;
      m_stat_q  <= STAT_AOK;
      m_icode_q <= I_NOP;
      m_cnd_q   <= 1'b0;
      m_val_e_q <= '0;
      m_val_a_q <= '0;
      m_dst_e_q <= RNONE;
      m_dst_m_q <= RNONE;
    end else begin
      cc_q      <= cc_d;
      m_stat_q  <= m_stat_d;
      m_icode_q <= m_icode_d;
      m_cnd_q   <= m_cnd_d;
      m_val_e_q <= m_val_e_d;
      m_val_a_q <= m_val_a_d;
      m_dst_e_q <= m_dst_e_d;
      m_dst_m_q <= m_dst_m_d;
    end
  end

  assign cc_o      = cc_q;
  assign m_stat_o  = m_stat_q;
  assign m_icode_o = m_icode_q;
  assign m_cnd_o   = m_cnd_q;
  assign m_valE_o  = m_val_e_q;
  assign m_valA_o  = m_val_a_q;
  assign m_dstE_o  = m_dst_e_q;
  assign m_dstM_o  = m_dst_m_q;

endmodule

// File: tb/tb_y86_execute_stage.sv
// Self-checking bench for y86_execute_stage: directed steps then randomized traffic against a reference model.
module tb_y86_execute_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_i;
   logic        bubble_i;
   logic        exc_i;
   logic [2:0]  e_stat_i;
   logic [3:0]  e_icode_i;
   logic [3:0]  e_ifun_i;
   logic [63:0] e_valA_i;
   logic [63:0] e_valB_i;
   logic [63:0] e_valC_i;
   logic [3:0]  e_dstE_i;
   logic [3:0]  e_dstM_i;
   logic [2:0]  m_stat_o;
   logic [3:0]  m_icode_o;
   logic        m_cnd_o;
   logic [63:0] m_valE_o;
   logic [63:0] m_valA_o;
   logic [3:0]  m_dstE_o;
   logic [3:0]  m_dstM_o;
   logic [2:0]  cc_o;

   int passCount = 0;
   int failCount = 0;
   int totalCount = 0;

   logic [2:0]  mdlCc;
   logic [2:0]  mdlStat;
   logic [3:0]  mdlIcode;
   logic        mdlCnd;
   logic [63:0] mdlValE;
   logic [63:0] mdlValA;
   logic [3:0]  mdlDstE;
   logic [3:0]  mdlDstM;

   // Ten-unit clock period
   always #5 clk = ~clk;

   y86_execute_stage #(.WIDTH(64), .STACK_STEP(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .stall_i   (stall_i),
      .bubble_i  (bubble_i),
      .exc_i     (exc_i),
      .e_stat_i  (e_stat_i),
      .e_icode_i (e_icode_i),
      .e_ifun_i  (e_ifun_i),
      .e_valA_i  (e_valA_i),
      .e_valB_i  (e_valB_i),
      .e_valC_i  (e_valC_i),
      .e_dstE_i  (e_dstE_i),
      .e_dstM_i  (e_dstM_i),
      .m_stat_o  (m_stat_o),
      .m_icode_o (m_icode_o),
      .m_cnd_o   (m_cnd_o),
      .m_valE_o  (m_valE_o),
      .m_valA_o  (m_valA_o),
      .m_dstE_o  (m_dstE_o),
      .m_dstM_o  (m_dstM_o),
      .cc_o      (cc_o)
   );

   // One comparison: counts it, and on a miss counts the failure and reports it
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      totalCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Named branch conditions evaluated from a {ZF,SF,OF} triple
   function automatic logic condHolds(input logic [3:0] fn, input logic [2:0] cc);
      logic zero, less;
      zero = cc[2];
      less = (cc[1] != cc[0]);
      case (fn)
         4'd0:    return 1'b1;
         4'd1:    return less || zero;
         4'd2:    return less;
         4'd3:    return zero;
         4'd4:    return !zero;
         4'd5:    return !less;
         4'd6:    return !less && !zero;
         default: return 1'b0;
      endcase
   endfunction

   task automatic modelReset();
      mdlCc    = 3'b100;
      mdlStat  = 3'd1;
      mdlIcode = 4'd1;
      mdlCnd   = 1'b0;
      mdlValE  = 64'd0;
      mdlValA  = 64'd0;
      mdlDstE  = 4'hF;
      mdlDstM  = 4'hF;
   endtask

   // Next-state of the reference model from the inputs currently driven
   task automatic modelStep();
      logic [63:0] a, b, r;
      logic signed [65:0] exact;
      logic ovf, c, allow;
      a = 64'd0;
      b = 64'd0;
      case (e_icode_i)
         4'h6, 4'h2:       a = e_valA_i;
         4'h3, 4'h4, 4'h5: a = e_valC_i;
         4'h8, 4'hA:       a = 64'd0 - 64'd8;
         4'h9, 4'hB:       a = 64'd8;
         default:          a = 64'd0;
      endcase
      if (e_icode_i inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) b = e_valB_i;
      ovf = 1'b0;
      if (e_icode_i == 4'h6 && e_ifun_i == 4'd1) begin
         r = b - a;
         exact = $signed({{2{b[63]}}, b}) - $signed({{2{a[63]}}, a});
         ovf = (exact != $signed({{2{r[63]}}, r}));
      end else if (e_icode_i == 4'h6 && e_ifun_i == 4'd2) begin
         r = b & a;
      end else if (e_icode_i == 4'h6 && e_ifun_i == 4'd3) begin
         r = b ^ a;
      end else if (e_icode_i == 4'h6 && e_ifun_i > 4'd3) begin
         r = 64'd0;
      end else begin
         r = b + a;
         exact = $signed({{2{b[63]}}, b}) + $signed({{2{a[63]}}, a});
         ovf = (exact != $signed({{2{r[63]}}, r}));
      end
      c = (e_icode_i == 4'h2 || e_icode_i == 4'h7) ? condHolds(e_ifun_i, mdlCc) : 1'b0;
`ifdef CC_SUPPRESS_EN
      allow = !exc_i && (e_stat_i == 3'd1);
`else
      allow = 1'b1;
`endif
      if (!stall_i) begin
         if (e_icode_i == 4'h6 && e_ifun_i <= 4'd3 && allow) mdlCc = {r == 64'd0, r[63], ovf};
         if (bubble_i) begin
            mdlStat  = 3'd1;
            mdlIcode = 4'd1;
            mdlCnd   = 1'b0;
            mdlValE  = 64'd0;
            mdlValA  = 64'd0;
            mdlDstE  = 4'hF;
            mdlDstM  = 4'hF;
         end else begin
            mdlStat  = e_stat_i;
            mdlIcode = e_icode_i;
            mdlCnd   = c;
            mdlValE  = r;
            mdlValA  = e_valA_i;
            mdlDstE  = (e_icode_i == 4'h2 && !c) ? 4'hF : e_dstE_i;
            mdlDstM  = e_dstM_i;
         end
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".stat"},  m_stat_o,  mdlStat);
      checkOutput({tag, ".icode"}, m_icode_o, mdlIcode);
      checkOutput({tag, ".cnd"},   m_cnd_o,   mdlCnd);
      checkOutput({tag, ".valE"},  m_valE_o,  mdlValE);
      checkOutput({tag, ".valA"},  m_valA_o,  mdlValA);
      checkOutput({tag, ".dstE"},  m_dstE_o,  mdlDstE);
      checkOutput({tag, ".dstM"},  m_dstM_o,  mdlDstM);
      checkOutput({tag, ".cc"},    cc_o,      mdlCc);
   endtask

   // Drive one instruction, advance the model, clock it in and compare
   task automatic applyStimulus(input string tag, input logic [3:0] icode, input logic [3:0] ifun,
                                input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                                input logic [3:0] dste, input logic [3:0] dstm, input logic [2:0] stat,
                                input logic stall, input logic bubble, input logic exc);
      e_icode_i = icode;
      e_ifun_i  = ifun;
      e_valA_i  = va;
      e_valB_i  = vb;
      e_valC_i  = vc;
      e_dstE_i  = dste;
      e_dstM_i  = dstm;
      e_stat_i  = stat;
      stall_i   = stall;
      bubble_i  = bubble;
      exc_i     = exc;
      modelStep();
      @(posedge clk);
      #1;
      checkAll(tag);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, ".cc"},    cc_o,      64'h4);
      checkOutput({tag, ".icode"}, m_icode_o, 64'h1);
      checkOutput({tag, ".stat"},  m_stat_o,  64'h1);
      checkOutput({tag, ".dstE"},  m_dstE_o,  64'hF);
      checkOutput({tag, ".dstM"},  m_dstM_o,  64'hF);
      checkOutput({tag, ".valE"},  m_valE_o,  64'h0);
   endtask

   // Directed steps first, then randomized traffic
   initial begin
      logic [63:0] ra, rb, rc;
      logic [3:0]  ricode, rifun;
      rst_n = 1'b0;
      stall_i = 1'b0; bubble_i = 1'b0; exc_i = 1'b0;
      e_stat_i = 3'd1; e_icode_i = 4'h1; e_ifun_i = 4'h0;
      e_valA_i = 64'd0; e_valB_i = 64'd0; e_valC_i = 64'd0;
      e_dstE_i = 4'hF; e_dstM_i = 4'hF;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkResetState("reset");
      rst_n = 1'b1;

      applyStimulus("add_of", 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h3, 4'hF, 3'd1, 1'b0, 1'b0, 1'b0);
      checkOutput("add_of.valE_lit", m_valE_o, 64'h8000_0000_0000_0000);
      checkOutput("add_of.cc_lit", cc_o, 64'h3);

      applyStimulus("sub_zero", 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h3, 4'hF, 3'd1, 1'b0, 1'b0, 1'b0);
      checkOutput("sub_zero.valE_lit", m_valE_o, 64'h0);
      checkOutput("sub_zero.cc_lit", cc_o, 64'h4);
      applyStimulus("jxx_e", 4'h7, 4'h3, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF, 3'd1, 1'b0, 1'b0, 1'b0);
      checkOutput("jxx_e.cnd_lit", m_cnd_o, 64'h1);
      applyStimulus("jxx_ne", 4'h7, 4'h4, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF, 3'd1, 1'b0, 1'b0, 1'b0);
      checkOutput("jxx_ne.cnd_lit", m_cnd_o, 64'h0);

      applyStimulus("and", 4'h6, 4'h2, 64'h26, 64'h31, 64'd0, 4'h2, 4'hF, 3'd1, 1'b0, 1'b0, 1'b0);
      checkOutput("and.valE_lit", m_valE_o, 64'h20);
      checkOutput("and.cc_lit", cc_o, 64'h0);
      applyStimulus("cmov_l", 4'h2, 4'h2, 64'h55, 64'd0, 64'd0, 4'h3, 4'hF, 3'd1, 1'b0, 1'b0, 1'b0);
      checkOutput("cmov_l.dstE_lit", m_dstE_o, 64'hF);
      checkOutput("cmov_l.cnd_lit", m_cnd_o, 64'h0);

      applyStimulus("push", 4'hA, 4'h0, 64'h9, 64'h100, 64'd0, 4'h4, 4'hF, 3'd1, 1'b0, 1'b0, 1'b0);
      checkOutput("push.valE_lit", m_valE_o, 64'hF8);
      applyStimulus("pop", 4'hB, 4'h0, 64'h100, 64'h100, 64'd0, 4'h4, 4'h7, 3'd1, 1'b0, 1'b0, 1'b0);
      checkOutput("pop.valE_lit", m_valE_o, 64'h108);
      checkOutput("pop.cc_lit", cc_o, 64'h0);

      applyStimulus("stall", 4'h6, 4'h1, 64'd7, 64'd9, 64'd0, 4'h1, 4'hF, 3'd1, 1'b1, 1'b1, 1'b0);
      checkOutput("stall.valE_lit", m_valE_o, 64'h108);
      checkOutput("stall.icode_lit", m_icode_o, 64'hB);
      applyStimulus("bubble", 4'h6, 4'h1, 64'd7, 64'd9, 64'd0, 4'h1, 4'hF, 3'd1, 1'b0, 1'b1, 1'b0);
      checkOutput("bubble.icode_lit", m_icode_o, 64'h1);
      applyStimulus("exc_sub", 4'h6, 4'h1, 64'd3, 64'd3, 64'd0, 4'h1, 4'hF, 3'd1, 1'b0, 1'b0, 1'b1);
      applyStimulus("ins_stat", 4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 4'h1, 4'hF, 3'd4, 1'b0, 1'b0, 1'b0);
      applyStimulus("opq_bad", 4'h6, 4'h5, 64'd1, 64'd1, 64'd0, 4'h1, 4'hF, 3'd1, 1'b0, 1'b0, 1'b0);

      applyStimulus("pre_rst", 4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 4'h2, 4'hF, 3'd1, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checkResetState("mid_rst");
      modelReset();
      #1 rst_n = 1'b1;

      for (int i = 0; i < 300; i++) begin
         ricode = 4'($urandom_range(0, 11));
         rifun  = (ricode == 4'h6) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) begin
            ra = 64'($urandom_range(0, 15));
            rb = 64'($urandom_range(0, 15));
         end else begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
         end
         rc = {$urandom, $urandom};
         applyStimulus($sformatf("rnd%0d", i), ricode, rifun, ra, rb, rc,
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       ($urandom_range(0, 4) == 0) ? 3'($urandom_range(2, 4)) : 3'd1,
                       $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0);
      end

      if (failCount != 0) $display("[TB] %0d comparisons did not match", failCount);
      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
